// File: rtl/fp_pkg.sv
// Shared constants for the FP32 multiplier round/pack path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fp_pkg;
   localparam int EXP_W  = 8;                  // exponent width
   localparam int MANT_W = 23;                 // stored fraction width
   localparam int BIAS   = 127;                // exponent bias
   localparam int SIG_W  = MANT_W + 1;         // significand incl. hidden bit
   localparam int PW     = 2 * SIG_W;          // significand product width

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   // out_flags = {invalid, overflow, underflow, inexact}
   localparam int FLAG_W        = 4;
   localparam int FLG_INVALID   = 3;
   localparam int FLG_OVERFLOW  = 2;
   localparam int FLG_UNDERFLOW = 1;
   localparam int FLG_INEXACT   = 0;
endpackage

// File: rtl/fp_rne_round.sv
// Round-to-nearest-even of a normalized significand using guard/sticky bits.
// Latency: combinational.
// Backpressure: none (pure function).
// Ports: sig_i/g_i/s_i in; sig_o rounded significand, carry_o set when the
// round-up overflowed to 2^SW (sig_o is then renormalized to 1.0),
// inexact_o set when any discarded bit was non-zero.
module fp_rne_round
   import fp_pkg::*;
#(
   parameter int SW = SIG_W
) (
   input  logic [SW-1:0] sig_i,
   input  logic          g_i,
   input  logic          s_i,
   output logic [SW-1:0] sig_o,
   output logic          carry_o,
   output logic          inexact_o
);

   logic          round_up;
   logic [SW:0]   sum;

   // Ties (G=1, S=0) round up only when the kept LSB is odd.
   assign round_up  = g_i & (s_i | sig_i[0]);
   assign sum       = {1'b0, sig_i} + {{SW{1'b0}}, round_up};
   assign carry_o   = sum[SW];
   // All-ones significand rounding up becomes exactly 2^SW; renormalize to 1.0.
   assign sig_o     = carry_o ? {1'b1, {(SW-1){1'b0}}} : sum[SW-1:0];
   assign inexact_o = g_i | s_i;

endmodule

// File: rtl/fp_mul_round_pack.sv
// Normalize, round-to-nearest-even and pack an FP32 product into IEEE754 single.
// Latency: 2 cycles input accept to out_valid; throughput 1 result/cycle.
// Backpressure: valid/ready; in_ready = !s1_valid | !s2_valid | out_ready, stalled stages hold.
// Ports: clk/rst (sync, active-high); in_* operand bundle (sign, signed exp sum
// expA+expB-BIAS, 48-bit significand product, special-case bits) with
// in_valid/in_ready; out_data {sign,exp,frac} with out_valid/out_ready;
// flags_clr and sticky out_flags {invalid,overflow,underflow,inexact}.
// Build option: FPMR_FLAGS_EN enables the sticky flag logic; otherwise
// out_flags is tied to zero and flags_clr is ignored.
module fp_mul_round_pack
   import fp_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sign,
   input  logic [EXP_W+1:0]  in_exp,
   input  logic [PW-1:0]     in_mant,
   input  logic              in_zero,
   input  logic              in_inf,
   input  logic              in_nan,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_data,
   input  logic              flags_clr,
   output logic [FLAG_W-1:0] out_flags
);

   // Internal exponent is widened so the two possible +1 increments and the
   // saturation compares never wrap.
   localparam int EW = EXP_W + 4;
   localparam logic signed [EW-1:0] EXP_SAT  = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] EXP_ZERO = '0;

   // ---------------- handshake ----------------
   logic s1_valid_q, s2_valid_q;
   logic s1_adv, s2_adv;

   assign s2_adv   = !s2_valid_q | out_ready;
   assign s1_adv   = !s1_valid_q | s2_adv;
   assign in_ready = s1_adv;

   // ---------------- S1: normalize ----------------
   logic                 norm_hi;
   logic signed [EW-1:0] exp_ext;
   logic signed [EW-1:0] s1_exp_d, s1_exp_q;
   logic [SIG_W-1:0]     s1_sig_d, s1_sig_q;
   logic                 s1_g_d, s1_g_q, s1_s_d, s1_s_q;
   logic                 s1_sign_q, s1_zero_q, s1_inf_q, s1_nan_q;

   // Product of two [1,2) significands lies in [1,4); bit PW-1 set means >= 2.
   assign norm_hi = in_mant[PW-1];
   assign exp_ext = {{2{in_exp[EXP_W+1]}}, in_exp};

   always_comb begin
      s1_sig_d = in_mant[PW-2 -: SIG_W];
      s1_g_d   = in_mant[PW-2-SIG_W];
      s1_s_d   = |in_mant[PW-3-SIG_W:0];
      s1_exp_d = exp_ext;
      if (norm_hi) begin
         s1_sig_d = in_mant[PW-1 -: SIG_W];
         s1_g_d   = in_mant[PW-1-SIG_W];
         s1_s_d   = |in_mant[PW-2-SIG_W:0];
         s1_exp_d = exp_ext + EW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
      end else if (s1_adv) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_sign_q <= in_sign;
            s1_exp_q  <= s1_exp_d;
            s1_sig_q  <= s1_sig_d;
            s1_g_q    <= s1_g_d;
            s1_s_q    <= s1_s_d;
            s1_zero_q <= in_zero;
            s1_inf_q  <= in_inf;
            s1_nan_q  <= in_nan;
         end
      end
   end

   // ---------------- S2: round and pack ----------------
   logic [SIG_W-1:0]     rnd_sig;
   logic                 rnd_carry, rnd_inexact;
   logic signed [EW-1:0] rnd_exp;
   logic                 ovf, unf;
   logic [31:0]          res_d, s2_data_q;

   fp_rne_round #(.SW(SIG_W)) u_rne (
      .sig_i     (s1_sig_q),
      .g_i       (s1_g_q),
      .s_i       (s1_s_q),
      .sig_o     (rnd_sig),
      .carry_o   (rnd_carry),
      .inexact_o (rnd_inexact)
   );

   // Range checks use the post-rounding exponent so a carry can push a
   // value into overflow.
   assign rnd_exp = s1_exp_q + {{(EW-1){1'b0}}, rnd_carry};
   assign ovf     = rnd_exp >= EXP_SAT;
   assign unf     = rnd_exp <= EXP_ZERO;

   always_comb begin
      res_d = {s1_sign_q, rnd_exp[EXP_W-1:0], rnd_sig[MANT_W-1:0]};
      if (s1_nan_q)
         res_d = QNAN;
      else if (s1_inf_q || (!s1_zero_q && ovf))
         res_d = {s1_sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      else if (s1_zero_q || unf)
         res_d = {s1_sign_q, {(EXP_W+MANT_W){1'b0}}};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
      end else if (s2_adv) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) s2_data_q <= res_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_data  = s2_data_q;

`ifdef FPMR_FLAGS_EN
   logic [FLAG_W-1:0] res_flags_d, s2_flags_q, flags_q;

   always_comb begin
      res_flags_d = '0;
      if (s1_nan_q) begin
         res_flags_d[FLG_INVALID] = 1'b1;
      end else if (s1_inf_q || s1_zero_q) begin
         res_flags_d = '0;
      end else if (ovf) begin
         res_flags_d[FLG_OVERFLOW] = 1'b1;
         res_flags_d[FLG_INEXACT]  = 1'b1;
      end else if (unf) begin
         res_flags_d[FLG_UNDERFLOW] = 1'b1;
         res_flags_d[FLG_INEXACT]   = 1'b1;
      end else begin
         res_flags_d[FLG_INEXACT] = rnd_inexact;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_flags_q <= '0;
         flags_q    <= '0;
      end else begin
         if (s2_adv && s1_valid_q) s2_flags_q <= res_flags_d;
         // A clear coincident with a transfer keeps only that result's flags.
         if (out_valid && out_ready)
            flags_q <= (flags_clr ? '0 : flags_q) | s2_flags_q;
         else if (flags_clr)
            flags_q <= '0;
      end
   end

   assign out_flags = flags_q;
`else
   logic unused_flag_inputs;
   assign unused_flag_inputs = ^{flags_clr, rnd_inexact};
   assign out_flags = '0;
`endif

endmodule

// File: tb/tb_fp_mul_round_pack.sv
// Scoreboard bench for fp_mul_round_pack: directed vectors with hand-computed results.
// Latency: n/a (testbench).
// Backpressure: exercises out_ready stalls, full-pipe pass-through and mid-stream reset.
module tb_fp_mul_round_pack;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid, in_ready, in_sign;
   logic [9:0]  in_exp;
   logic [47:0] in_mant;
   logic        in_zero, in_inf, in_nan;
   logic        out_valid, out_ready;
   logic [31:0] out_data;
   logic        flags_clr;
   logic [3:0]  out_flags;

   fp_mul_round_pack dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sign   (in_sign),
      .in_exp    (in_exp),
      .in_mant   (in_mant),
      .in_zero   (in_zero),
      .in_inf    (in_inf),
      .in_nan    (in_nan),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .flags_clr (flags_clr),
      .out_flags (out_flags)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          sign;
      int          e;
      logic [47:0] m;
      bit          z, i, n;
      logic [31:0] d;
      logic [3:0]  f;   // {invalid, overflow, underflow, inexact}
   } vec_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_d_q[$];
   logic [3:0]  exp_f_q[$];
   vec_t        vecs[17];

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic send(input vec_t v, input logic ordy, output int waited);
      @(negedge clk);
      out_ready = ordy;
      in_sign   = v.sign;
      in_exp    = v.e[9:0];
      in_mant   = v.m;
      in_zero   = v.z;
      in_inf    = v.i;
      in_nan    = v.n;
      in_valid  = 1'b1;
      waited    = 0;
      #1;
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (in_ready) begin
         exp_d_q.push_back(v.d);
         exp_f_q.push_back(v.f);
         @(posedge clk);
         #1;
      end else begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: in_ready stuck low, expected 1");
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_d_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check32("drain_empty", exp_d_q.size(), 0);
   endtask

   // Monitor: pops the scoreboard on every output transfer and tracks the
   // expected sticky flag register.
   initial begin : monitor
      logic [3:0]  fm;
      logic [3:0]  rf;
      logic [31:0] ed;
      bit          xfer;
      fm = '0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst) check32("flags", {28'd0, out_flags}, {28'd0, fm});
         xfer = !rst && out_valid && out_ready;
         rf   = '0;
         if (xfer) begin
            if (exp_d_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_output: got %h, expected no transfer", out_data);
            end else begin
               ed = exp_d_q.pop_front();
               rf = exp_f_q.pop_front();
               check32("out_data", out_data, ed);
            end
         end
`ifdef FPMR_FLAGS_EN
         if (rst)            fm = '0;
         else if (xfer)      fm = (flags_clr ? 4'b0 : fm) | rf;
         else if (flags_clr) fm = '0;
`endif
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int   w;
      vec_t vc;
      in_valid = 0; in_sign = 0; in_exp = 0; in_mant = 0;
      in_zero = 0; in_inf = 0; in_nan = 0; out_ready = 1; flags_clr = 0;

      //          sign  exp   mant               z  i  n   result        flags
      vecs[0]  = '{0,   127, 48'h400000000000, 0, 0, 0, 32'h3F800000, 4'b0000};
      vecs[1]  = '{0,   127, 48'h900000000000, 0, 0, 0, 32'h40100000, 4'b0000};
      vecs[2]  = '{0,   127, 48'h400000400000, 0, 0, 0, 32'h3F800000, 4'b0001};
      vecs[3]  = '{0,   127, 48'h400000C00000, 0, 0, 0, 32'h3F800002, 4'b0001};
      vecs[4]  = '{0,   127, 48'h7FFFFFC00000, 0, 0, 0, 32'h40000000, 4'b0001};
      vecs[5]  = '{0,   300, 48'h7FFFFFC00000, 0, 0, 0, 32'h7F800000, 4'b0101};
      vecs[6]  = '{0,   0,   48'h400000000000, 0, 0, 0, 32'h00000000, 4'b0011};
      vecs[7]  = '{0,   0,   48'h000000000000, 0, 0, 1, 32'h7FC00000, 4'b1000};
      vecs[8]  = '{1,   0,   48'h000000000000, 0, 1, 0, 32'hFF800000, 4'b0000};
      vecs[9]  = '{1,   0,   48'h000000000000, 1, 0, 0, 32'h80000000, 4'b0000};
      vecs[10] = '{1,   254, 48'h400000000000, 0, 0, 0, 32'hFF000000, 4'b0000};
      vecs[11] = '{0,   254, 48'h7FFFFFC00000, 0, 0, 0, 32'h7F800000, 4'b0101};
      vecs[12] = '{0,   1,   48'h400000000000, 0, 0, 0, 32'h00800000, 4'b0000};
      vecs[13] = '{0,   -5,  48'h400000000000, 0, 0, 0, 32'h00000000, 4'b0011};
      vecs[14] = '{1,   127, 48'h400000000000, 0, 1, 1, 32'h7FC00000, 4'b1000};
      vecs[15] = '{0,   127, 48'hC00000C00000, 0, 0, 0, 32'h40400001, 4'b0001};
      vecs[16] = '{0,   300, 48'h400000000000, 0, 1, 0, 32'h7F800000, 4'b0000};

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check32("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check32("rst_out_data", out_data, 32'd0);
      check32("rst_out_flags", {28'd0, out_flags}, 32'd0);
      check32("rst_in_ready", {31'd0, in_ready}, 32'd1);
      rst = 1'b0;

      // Back-to-back stream with out_ready held high: never stalls.
      for (int k = 0; k < 17; k++) begin
         send(vecs[k], 1'b1, w);
         check32("stream_in_ready_wait", w, 0);
      end
      drain();

      // Backpressure: two bundles fill the pipe, a third is refused.
      send(vecs[0], 1'b0, w);
      send(vecs[1], 1'b0, w);
      vc = vecs[7];
      @(negedge clk);
      in_sign = vc.sign; in_exp = vc.e[9:0]; in_mant = vc.m;
      in_zero = vc.z; in_inf = vc.i; in_nan = vc.n; in_valid = 1'b1;
      #1;
      check32("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check32("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check32("stall_head_data", out_data, 32'h3F800000);
      @(negedge clk);
      #1;
      check32("stall_in_ready_held", {31'd0, in_ready}, 32'd0);
      check32("stall_head_held", out_data, 32'h3F800000);
      // Release while full: accept and emit in the same cycle.
      send(vc, 1'b1, w);
      check32("full_pass_through_wait", w, 0);
      drain();

      // Flag clear alone, then clear coincident with a transfer.
      @(negedge clk); flags_clr = 1'b1;
      @(negedge clk); flags_clr = 1'b0;
      send(vecs[5], 1'b1, w);
      send(vecs[2], 1'b1, w);
      @(negedge clk);
      flags_clr = 1'b1;   // first result transfers at the coming edge
      @(negedge clk);
      flags_clr = 1'b0;
      drain();

      // Reset mid-stream drops in-flight results.
      send(vecs[3], 1'b1, w);
      send(vecs[4], 1'b1, w);
      @(negedge clk);
      rst = 1'b1;
      exp_d_q.delete();
      exp_f_q.delete();
      @(negedge clk);
      #1;
      check32("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check32("midrst_out_data", out_data, 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check32("midrst_quiet", {31'd0, out_valid}, 32'd0);

      // Recovery after reset.
      send(vecs[15], 1'b1, w);
      drain();

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
